soc_system_key_debounce: RTL and testbench

//  Per-bit debouncer for the DE1-SoC push-buttons (active-low, idle 1).
//  - Sits between the KEY[3:0] board pins and the key PIO in_port.
//  - Synchronises each raw key, rejects bounce shorter than DEBOUNCE_CYCLES,
//    and drives a clean, level-preserving copy that the PIO edge logic samples.
//  - Also emits one-cycle press/release strobes for fabric logic.

---
 rtl/soc_system_key_debounce.sv | 101 ++++++++++
 tb/tb_soc_system_key_debounce.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/soc_system_key_debounce.sv
// Per-bit push-button debouncer: 2-flop sync, stability counter, clean level
// output plus one-cycle press/release strobes.
module soc_system_key_debounce #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] key_raw,
  output logic [WIDTH-1:0] key_out,
  output logic [WIDTH-1:0] press_pulse,
  output logic [WIDTH-1:0] release_pulse
);

  typedef enum logic {
    S_STABLE = 1'b0,
    S_WAIT   = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] key_s;

  state_t           state_q [WIDTH];
  state_t           state_d [WIDTH];
  logic [CNT_W-1:0] cnt_q   [WIDTH];
  logic [CNT_W-1:0] cnt_d   [WIDTH];

  logic [WIDTH-1:0] out_d;
  logic [WIDTH-1:0] press_d;
  logic [WIDTH-1:0] rel_d;

  // Idle level of the buttons is 1, so the synchroniser resets high.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= '1;
      key_s <= '1;
    end else begin
      sync1 <= key_raw;
      key_s <= sync1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < WIDTH; i++) begin
        state_q[i] <= S_STABLE;
        cnt_q[i]   <= '0;
      end
      key_out       <= '1;
      press_pulse   <= '0;
      release_pulse <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      key_out       <= out_d;
      press_pulse   <= press_d;
      release_pulse <= rel_d;
    end
  end

  always_comb begin
    out_d   = key_out;
    press_d = '0;
    rel_d   = '0;
    for (int i = 0; i < WIDTH; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      unique case (state_q[i])
        S_STABLE: begin
          if (key_s[i] != key_out[i]) begin
            state_d[i] = S_WAIT;
            cnt_d[i]   = CNT_W'(1);
          end else begin
            cnt_d[i] = '0;
          end
        end
        S_WAIT: begin
          if (key_s[i] == key_out[i]) begin
            state_d[i] = S_STABLE;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == LAST) begin
            // D-th consecutive differing sample: commit the new level.
            out_d[i]   = key_s[i];
            press_d[i] = ~key_s[i];
            rel_d[i]   = key_s[i];
            state_d[i] = S_STABLE;
            cnt_d[i]   = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_soc_system_key_debounce.sv
// Bench for soc_system_key_debounce: table vectors, hand sequences and
// random stimulus checked every cycle against a window-based model.
module tb_soc_system_key_debounce;

  localparam int D = 8;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] key_raw;
  logic [3:0] key_out;
  logic [3:0] press_pulse;
  logic [3:0] release_pulse;

  int total = 0;
  int bad   = 0;

  soc_system_key_debounce #(
    .WIDTH(4),
    .DEBOUNCE_CYCLES(D),
    .CNT_W(4)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .key_raw(key_raw),
    .key_out(key_out),
    .press_pulse(press_pulse),
    .release_pulse(release_pulse)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [3:0] act,
                       input logic [3:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %h want %h", name, $time, act, exp);
    end
  endtask

  // Model: key_s is the raw pin delayed two edges; a bit flips once the
  // last D key_s samples since reset all disagree with its current level.
  logic [3:0] m_out, m_press, m_rel, p0, p1;
  logic [3:0] win[$];

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_out   = 4'hF;
      m_press = 4'h0;
      m_rel   = 4'h0;
      p0      = 4'hF;
      p1      = 4'hF;
      win     = {};
    end else begin
      win.push_back(p1);
      if (win.size() > D) void'(win.pop_front());
      m_press = 4'h0;
      m_rel   = 4'h0;
      if (win.size() == D) begin
        for (int i = 0; i < 4; i++) begin
          bit all_diff;
          all_diff = 1'b1;
          foreach (win[k])
            if (win[k][i] == m_out[i]) all_diff = 1'b0;
          if (all_diff) begin
            m_out[i] = ~m_out[i];
            if (m_out[i]) m_rel[i] = 1'b1;
            else          m_press[i] = 1'b1;
          end
        end
      end
      p1 = p0;
      p0 = key_raw;
    end
  end

  bit chk_en = 1'b0;

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_key_out", key_out, m_out);
      check("model_press", press_pulse, m_press);
      check("model_release", release_pulse, m_rel);
      check("press_and_release", press_pulse & release_pulse, 4'h0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [3:0] raw;
    int         hold;
    logic [3:0] exp_out;
    logic [3:0] exp_press;
    logic [3:0] exp_rel;
  } vec_t;

  vec_t vecs[$];

  initial begin
    logic [3:0] acc_p, acc_r;

    vecs.push_back('{4'hF, 50, 4'hF, 4'h0, 4'h0});
    for (int r = 0; r < 4; r++) begin
      vecs.push_back('{4'hD, 3, 4'hF, 4'h0, 4'h0});
      vecs.push_back('{4'hF, 2, 4'hF, 4'h0, 4'h0});
    end
    vecs.push_back('{4'hD, 20, 4'hD, 4'h2, 4'h0});
    vecs.push_back('{4'hF, 20, 4'hF, 4'h0, 4'h2});
    vecs.push_back('{4'hB, 7, 4'hF, 4'h0, 4'h0});
    vecs.push_back('{4'hF, 20, 4'hF, 4'h0, 4'h0});
    vecs.push_back('{4'h0, 20, 4'h0, 4'hF, 4'h0});
    vecs.push_back('{4'hF, 20, 4'hF, 4'h0, 4'hF});
    vecs.push_back('{4'h6, 20, 4'h6, 4'h9, 4'h0});
    vecs.push_back('{4'hF, 20, 4'hF, 4'h0, 4'h9});

    key_raw = 4'hF;
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    chk_en = 1'b1;
    #1;
    check("reset_key_out", key_out, 4'hF);
    check("reset_press", press_pulse, 4'h0);
    check("reset_release", release_pulse, 4'h0);
    repeat (3) tick();
    reset_n = 1'b1;

    foreach (vecs[v]) begin
      key_raw = vecs[v].raw;
      acc_p = 4'h0;
      acc_r = 4'h0;
      repeat (vecs[v].hold) begin
        tick();
        acc_p |= press_pulse;
        acc_r |= release_pulse;
      end
      check($sformatf("vec%0d_out", v), key_out, vecs[v].exp_out);
      check($sformatf("vec%0d_press", v), acc_p, vecs[v].exp_press);
      check($sformatf("vec%0d_rel", v), acc_r, vecs[v].exp_rel);
    end

    // Clean press: key_out falls exactly 10 edges after the pin.
    key_raw = 4'hE;
    repeat (9) tick();
    check("press_t9_out", key_out, 4'hF);
    tick();
    check("press_t10_out", key_out, 4'hE);
    check("press_t10_pulse", press_pulse, 4'h1);
    tick();
    check("press_t11_pulse", press_pulse, 4'h0);
    key_raw = 4'hF;
    repeat (12) tick();
    check("press_released", key_out, 4'hF);

    // All keys at once: same-cycle fall and rise.
    key_raw = 4'h0;
    repeat (10) tick();
    check("simul_out", key_out, 4'h0);
    check("simul_press", press_pulse, 4'hF);
    key_raw = 4'hF;
    repeat (10) tick();
    check("simul_rel", release_pulse, 4'hF);

    // Reset four cycles into a held press.
    key_raw = 4'hE;
    repeat (4) tick();
    reset_n = 1'b0;
    #1;
    check("rst_wait_out", key_out, 4'hF);
    tick();
    reset_n = 1'b1;
    repeat (9) tick();
    check("rst_requal_t9", key_out, 4'hF);
    tick();
    check("rst_requal_t10", key_out, 4'hE);
    check("rst_requal_pulse", press_pulse, 4'h1);
    key_raw = 4'hF;
    repeat (12) tick();

    // Random segments, compared every cycle against the model.
    for (int s = 0; s < 400; s++) begin
      key_raw = 4'($urandom);
      repeat ($urandom_range(1, 12)) tick();
      if (s == 200) begin
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
      end
    end
    key_raw = 4'hF;
    repeat (15) tick();
    check("final_idle", key_out, 4'hF);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
